// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clamped parallel load and wrap/saturate/bounce end-of-range.
// All outputs registered, every input acts on the next clk edge; no flow control.
module updown_counter_param #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int MODE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] counter_out,
  output logic             dir_out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_e;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             eff_up;
  logic             at_bound;

  // Only bounce mode keeps its own direction; the others follow the pin.
  assign eff_up = (MODE == 2) ? (dir_q == UP) : direction;

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~clr_ovf;
    at_bound = 1'b0;
    if (MODE != 2) dir_d = dir_e'(direction);

    if (load) begin
      cnt_d = (load_value > MAX) ? MAX : load_value;
      if (MODE == 2) dir_d = dir_e'(direction);
    end else if (enable) begin
      at_bound = eff_up ? (cnt_q == MAX) : (cnt_q == '0);
      tc_d     = at_bound;
      if (at_bound) begin
        if (MODE == 0) begin
          cnt_d = eff_up ? '0 : MAX;
          ovf_d = 1'b1;
        end else if (MODE == 1) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = eff_up ? (MAX - 1'b1) : WIDTH'(1);
          dir_d = eff_up ? DOWN : UP;
        end
      end else begin
        cnt_d = eff_up ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= UP;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign counter_out = cnt_q;
  assign dir_out     = dir_q;
  assign tc          = tc_q;
  assign ovf         = ovf_q;

endmodule
